// File: rtl/mc_alu16_result_sink_pkg.sv
// rtl/mc_alu16_result_sink_pkg.sv - shared types for the multicycle ALU result sink
package rfPhoenixPkg;

    localparam int RDW = 6;

    typedef logic [3:0]  tid_t;
    typedef logic [15:0] half_value_t;

    typedef struct packed {
        tid_t            tid;
        logic [RDW-1:0]  rd;
        half_value_t     res;
    } mc_wb_entry_t;

endpackage

// File: rtl/mc_alu16_result_sink_fifo.sv
// rtl/mc_alu16_result_sink_fifo.sv - show-ahead result FIFO with wrap-bit pointers
module mc_result_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             empty,
    output logic             full,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // Head reads as zero when empty so stale storage never leaks onto the writeback bus.
    assign head  = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/mc_alu16_result_sink.sv
// rtl/mc_alu16_result_sink.sv - ALU result tracking, buffering and issue credits; option MC_RESULT_TAG_CHECK_EN
module mc_alu16_result_sink
    import rfPhoenixPkg::*;
#(
    parameter int LATENCY = 8,
    parameter int DEPTH   = 16,
    parameter int RDW     = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_v,
    input  tid_t                       issue_tid,
    input  logic [RDW-1:0]             issue_rd,
    output logic                       issue_rdy,
    input  half_value_t                res_i,
    input  tid_t                       rid_i,
    output logic                       wb_v,
    input  logic                       wb_rdy,
    output tid_t                       wb_tid,
    output logic [RDW-1:0]             wb_rd,
    output half_value_t                wb_res,
    output logic [$clog2(DEPTH+1)-1:0] inflight,
    output logic                       tag_err
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = $bits(tid_t) + RDW + $bits(half_value_t);

    logic               iss;
    logic               pop;
    logic               cap;
    logic               fifo_empty;
    logic               fifo_full;
    logic [EW-1:0]      fifo_head;
    logic [LATENCY-1:0] trk_v;
    tid_t               trk_tid [LATENCY];
    logic [RDW-1:0]     trk_rd  [LATENCY];

    // Ops offered without credit are dropped here, never tracked or counted.
    assign iss = issue_v & issue_rdy;
    assign pop = wb_v & wb_rdy;
    assign cap = trk_v[LATENCY-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trk_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                trk_tid[i] <= '0;
                trk_rd[i]  <= '0;
            end
        end else begin
            trk_v      <= {trk_v[LATENCY-2:0], iss};
            trk_tid[0] <= issue_tid;
            trk_rd[0]  <= issue_rd;
            for (int i = 1; i < LATENCY; i++) begin
                trk_tid[i] <= trk_tid[i-1];
                trk_rd[i]  <= trk_rd[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            case ({iss, pop})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Credits cover pipe plus FIFO, so a capture can never meet a full FIFO.
    assign issue_rdy = (inflight < CW'(DEPTH));

    mc_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap),
        .din   ({trk_tid[LATENCY-1], trk_rd[LATENCY-1], res_i}),
        .pop   (pop),
        .empty (fifo_empty),
        .full  (fifo_full),
        .head  (fifo_head)
    );

    assign wb_v                     = !fifo_empty;
    assign {wb_tid, wb_rd, wb_res}  = fifo_head;

`ifdef MC_RESULT_TAG_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_err <= 1'b0;
        end else if (cap && (rid_i != trk_tid[LATENCY-1])) begin
            tag_err <= 1'b1;
        end
    end
`else
    logic unused_rid;
    assign unused_rid = ^rid_i;
    assign tag_err    = 1'b0;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst) begin
            assert (!(issue_v && !issue_rdy))
                else $warning("issue_v without credit, op dropped");
            assert (!(cap && fifo_full && !pop))
                else $error("capture into full result FIFO");
        end
    end
`endif

endmodule

// File: tb/tb_mc_alu16_result_sink.sv
// tb/tb_mc_alu16_result_sink.sv - directed self-checking bench for mc_alu16_result_sink
module tb_mc_alu16_result_sink;
    import rfPhoenixPkg::*;

    localparam int L = 8;
    localparam int D = 16;
`ifdef MC_RESULT_TAG_CHECK_EN
    localparam logic TAG_EXP = 1'b1;
`else
    localparam logic TAG_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_v = 1'b0;
    tid_t        issue_tid = '0;
    logic [5:0]  issue_rd = '0;
    logic        issue_rdy;
    half_value_t res_i = '0;
    tid_t        rid_i = '0;
    logic        wb_v;
    logic        wb_rdy = 1'b0;
    tid_t        wb_tid;
    logic [5:0]  wb_rd;
    half_value_t wb_res;
    logic [4:0]  inflight;
    logic        tag_err;

    half_value_t issue_res = '0;
    logic        issue_bad = 1'b0;

    logic        alu_v [L];
    logic        trk_v [L];
    logic        alu_bad [L];
    logic [25:0] alu_ent [L];
    logic [25:0] sb [$];
    int          exp_infl = 0;
    int          pops = 0;
    int          accepted = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mc_alu16_result_sink #(.LATENCY(L), .DEPTH(D), .RDW(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .issue_v   (issue_v),
        .issue_tid (issue_tid),
        .issue_rd  (issue_rd),
        .issue_rdy (issue_rdy),
        .res_i     (res_i),
        .rid_i     (rid_i),
        .wb_v      (wb_v),
        .wb_rdy    (wb_rdy),
        .wb_tid    (wb_tid),
        .wb_rd     (wb_rd),
        .wb_res    (wb_res),
        .inflight  (inflight),
        .tag_err   (tag_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        exp_infl = 0;
        for (int i = 0; i < L; i++) trk_v[i] = 1'b0;
    endtask

    // One clock: drive ALU outputs, check against the model at the falling edge, then advance the model.
    task automatic tick();
        logic acc;
        logic pp;
        #4;
        res_i = alu_v[L-1] ? alu_ent[L-1][15:0] : 16'h0;
        rid_i = alu_v[L-1] ? (alu_bad[L-1] ? 4'd7 : alu_ent[L-1][25:22]) : 4'd0;
        chk("wb_v", 32'(wb_v), 32'(sb.size() != 0));
        if (sb.size() != 0) chk("wb_entry", {6'd0, wb_tid, wb_rd, wb_res}, {6'd0, sb[0]});
        chk("issue_rdy", 32'(issue_rdy), 32'(exp_infl < D));
        chk("inflight", 32'(inflight), 32'(exp_infl));
        acc = rst && issue_v && (exp_infl < D);
        pp  = rst && (sb.size() != 0) && wb_rdy;
        @(posedge clk);
        #1;
        if (!rst) begin
            model_reset();
        end else begin
            if (pp) begin
                void'(sb.pop_front());
                pops++;
            end
            if (trk_v[L-1]) sb.push_back({alu_ent[L-1][25:16], res_i});
            if (acc) accepted++;
            exp_infl = exp_infl + (acc ? 1 : 0) - (pp ? 1 : 0);
        end
        for (int i = L-1; i > 0; i--) begin
            alu_v[i]   = alu_v[i-1];
            trk_v[i]   = trk_v[i-1];
            alu_bad[i] = alu_bad[i-1];
            alu_ent[i] = alu_ent[i-1];
        end
        alu_v[0]   = acc;
        trk_v[0]   = acc;
        alu_bad[0] = issue_bad;
        alu_ent[0] = {issue_tid, issue_rd, issue_res};
    endtask

    task automatic issue(input int tid, input int rd, input logic [15:0] r);
        issue_v   = 1'b1;
        issue_tid = tid_t'(tid);
        issue_rd  = 6'(rd);
        issue_res = r;
        tick();
        issue_v   = 1'b0;
    endtask

    initial begin
        int p0;
        for (int i = 0; i < L; i++) begin
            alu_v[i] = 1'b0; trk_v[i] = 1'b0; alu_bad[i] = 1'b0; alu_ent[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_v", 32'(wb_v), 32'd0);
        chk("rst_wb_fields", {6'd0, wb_tid, wb_rd, wb_res}, 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_issue_rdy", 32'(issue_rdy), 32'd1);
        chk("rst_tag_err", 32'(tag_err), 32'd0);
        rst = 1'b1;

        // single op: wb_v rises LATENCY+1 cycles after issue
        issue(3, 5, 16'h3C00);
        repeat (7) tick();
        chk("single_early", 32'(wb_v), 32'd0);
        tick();
        chk("single_wb_v", 32'(wb_v), 32'd1);
        chk("single_tid", 32'(wb_tid), 32'd3);
        chk("single_rd", 32'(wb_rd), 32'd5);
        chk("single_res", 32'(wb_res), 32'h3C00);
        wb_rdy = 1'b1;
        tick();
        chk("single_pop_v", 32'(wb_v), 32'd0);
        chk("single_pop_infl", 32'(inflight), 32'd0);

        // streaming: 20 back-to-back ops drain back-to-back within 29 cycles
        p0 = pops;
        for (int i = 0; i < 20; i++) begin
            issue(i % 16, i + 8, 16'h1000 + 16'(i));
            chk("stream_rdy", 32'(issue_rdy), 32'd1);
        end
        repeat (9) tick();
        chk("stream_pops", 32'(pops - p0), 32'd20);

        // backpressure: credits exhaust at DEPTH outstanding ops
        wb_rdy = 1'b0;
        for (int i = 0; i < 16; i++) issue(15 - i, i, 16'hA000 + 16'(i));
        chk("bp_rdy_low", 32'(issue_rdy), 32'd0);
        chk("bp_infl_full", 32'(inflight), 32'd16);
        issue(9, 9, 16'hDEAD);
        chk("bp_drop_infl", 32'(inflight), 32'd16);
        repeat (8) tick();
        wb_rdy = 1'b1;
        tick();
        wb_rdy = 1'b0;
        chk("bp_rdy_back", 32'(issue_rdy), 32'd1);
        chk("bp_infl_15", 32'(inflight), 32'd15);
        wb_rdy = 1'b1;
        repeat (20) tick();
        chk("bp_drained", 32'(inflight), 32'd0);

        // wrap: occupancy swings between empty and full across three periods
        p0 = pops;
        accepted = 0;
        for (int c = 0; c < 180; c++) begin
            wb_rdy    = (c % 60) >= 30;
            issue_v   = (exp_infl < D) && ((c % 60) < 40);
            issue_tid = tid_t'(c);
            issue_rd  = 6'(c * 3);
            issue_res = 16'(c * 16'h0107);
            tick();
        end
        issue_v = 1'b0;
        wb_rdy  = 1'b1;
        repeat (30) tick();
        chk("wrap_count", 32'(pops - p0), 32'(accepted));
        chk("wrap_empty", 32'(wb_v), 32'd0);

        // tag check: ALU returns rid 7 for an op tracked as tid 2
        wb_rdy = 1'b0;
        issue_bad = 1'b1;
        issue(2, 11, 16'h5555);
        issue_bad = 1'b0;
        repeat (8) tick();
        chk("tag_err", 32'(tag_err), 32'(TAG_EXP));
        chk("tag_tid", 32'(wb_tid), 32'd2);
        wb_rdy = 1'b1;
        tick();

        // async reset with 4 ops in the pipe and 3 in the FIFO
        wb_rdy = 1'b0;
        for (int i = 0; i < 7; i++) issue(i + 4, i + 20, 16'hC000 + 16'(i));
        repeat (4) tick();
        chk("pre_rst_infl", 32'(inflight), 32'd7);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_wb_v", 32'(wb_v), 32'd0);
        chk("arst_infl", 32'(inflight), 32'd0);
        chk("arst_rdy", 32'(issue_rdy), 32'd1);
        chk("arst_tag", 32'(tag_err), 32'd0);
        chk("arst_fields", {6'd0, wb_tid, wb_rd, wb_res}, 32'd0);
        model_reset();
        tick();
        rst = 1'b1;
        repeat (10) tick();
        chk("post_rst_wb_v", 32'(wb_v), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
